median_axis_tx_buffer: RTL and testbench
========================================

Name: median_axis_tx_buffer

Overview:
- Output stage of the median 5x5 pipeline: accepts the valid-only pixel stream from the median processing stage and drives a full AXI4-Stream video master with back-pressure (m_axis_tready).
- Buffers pixels in a small synchronous FIFO.
- Regenerates tuser (start of frame) and tlast (end of line) from runtime WIDTH/HEIGHT.
- Flags overflow when the downstream sink stalls longer than the FIFO can absorb.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- DIM_WIDTH, 13, width of WIDTH/HEIGHT and of the line/row counters.

Ports:
- i_clk  in  1  system clock.
- i_areset  in  1  asynchronous, active-high reset.
- WIDTH  in  DIM_WIDTH  output line length in pixels; sampled on sof.
- HEIGHT  in  DIM_WIDTH  output frame height in lines; sampled on sof.
- i_median_pixel  in  DATA_WIDTH  filtered pixel.
- i_image_data_valid  in  1  pixel valid; no back-pressure upstream.
- i_start_of_frame  in  1  marks first pixel of a frame; qualified by valid.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tuser  out  1  start of frame, on first beat only.
- m_axis_tlast  out  1  last beat of each line.
- o_overflow  out  1  sticky: a pixel was dropped.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_frame_done  out  1  one-cycle pulse on the handshake of the last beat of a frame.

Behaviour:
- Reset: all outputs 0; FIFO empty; counters 0; FSM in IDLE. Asserting reset mid-frame discards the FIFO contents and the partial frame.
- FIFO entry: {sof_flag, pixel}.
- Write condition: valid and FSM not IDLE, or valid and sof (a sof pixel is also written while in IDLE).
- Read condition: m_axis_tvalid and m_axis_tready.
- FSM IDLE: input pixels without sof are discarded and do not set overflow. On valid and sof: latch WIDTH/HEIGHT (a value of 0 is clamped to 1), write the entry, go to ACTIVE.
- FSM ACTIVE: writes accepted. When the head entry of the final pixel (col==W-1, row==H-1) handshakes: pulse o_frame_done, go to IDLE. A sof arriving mid-frame re-latches WIDTH/HEIGHT and stays in ACTIVE; earlier entries still drain.
- Output counters (col, row) advance only on the read handshake:
  - col wraps at W-1, then row increments.
  - If the head entry has sof_flag set, that beat is treated as col=0, row=0 regardless of the counter values.
  - tuser = head sof_flag.
  - tlast = (effective col == W-1).
- Latency: a pixel written at clock edge N appears on m_axis at cycle N+1 if the FIFO was empty. No combinational path from input to output.
- m_axis_tdata/tuser/tlast are stable while tvalid=1 and tready=0. tvalid never drops without a handshake.
- Full: a write while full and no read in that cycle drops the pixel and sets o_overflow (sticky until reset). A write while full in the same cycle as a read is accepted; the level is unchanged.
- Empty with simultaneous write: no bypass; tvalid rises the next cycle.
- A dropped sof pixel still causes the FSM transition and register latch, but no tuser is emitted for it.
- o_fifo_level updates one cycle after the write/read edge.

Optional Feature:
- Macro MEDIAN_TX_DROP_COUNT_EN.
- Defined: adds output port o_drop_count (16 bits). It counts dropped pixels, saturates at 0xFFFF, and clears only on reset.
- Undefined: the port and counter are absent; o_overflow behaviour is unchanged.

Decomposition:
- Package median_pkg:
  - DIM_WIDTH default constant.
  - typedef enum {IDLE, ACTIVE} tx_state_t.
  - Parameterised struct-style fifo entry type {sof, data}.
- Sub-module median_tx_sync_fifo: single clock, async active-high reset, FWFT head output, full/empty/level, simultaneous read/write when full allowed.
- Counters and FSM stay in the top module.

Test Plan:
1. Basic frame: WIDTH=4, HEIGHT=3, 12 contiguous valid pixels 1..12 with sof on pixel 1, tready=1 -> 12 beats 1..12; tuser only on beat 1; tlast on beats 4, 8, 12; o_frame_done pulses on beat 12; o_overflow=0.
2. Back-pressure: FIFO_DEPTH=16, WIDTH=8, HEIGHT=4, tready=0 for the first 20 input pixels -> o_fifo_level reaches 16; pixels 17..20 dropped; o_overflow=1; drop count=4 if the macro is defined; output resumes with pixels 1..16 in order and tdata stable while stalled.
3. Full plus simultaneous read: FIFO full, tready=1 and valid in the same cycle -> write accepted; level stays 16; no overflow.
4. Pre-sof garbage: 5 valid pixels without sof after reset, then a sof frame -> no output for the first 5; o_overflow=0; first output beat has tuser=1.
5. Mid-frame sof: WIDTH=4, HEIGHT=2, sof re-asserted on the 6th pixel -> beat 6 has tuser=1 with col restarted at 0; tlast on beats 4 and 9.
6. Reset mid-frame: i_areset asserted with 5 entries buffered -> tvalid=0 and level=0 immediately; the next sof frame outputs correctly from col 0.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and constants for the median 5x5 AXI4-Stream output stage.
package median_pkg;

   // Default width of WIDTH/HEIGHT and of the column/row counters.
   localparam int unsigned MEDIAN_DIM_WIDTH = 13;

   // Transmit framing state: IDLE discards pixels until a start of frame.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } tx_state_t;

   // A FIFO entry is {sof, data}; the packed struct itself is declared where
   // DATA_WIDTH is known, this gives its flattened width.
   function automatic int unsigned fifo_entry_width(input int unsigned data_width);
      return data_width + 1;
   endfunction

endpackage

// File: rtl/median_tx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A write while full is accepted
// when a read happens in the same cycle.
module median_tx_sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_areset,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_fire;
   logic             rd_fire;

   // Accept/pop decisions; a full write rides on a same-cycle pop.
   always_comb begin
      o_full    = (count == DEPTH_L);
      o_empty   = (count == '0);
      rd_fire   = i_rd_en && !o_empty;
      wr_fire   = i_wr_en && (!o_full || rd_fire);
      o_rd_data = mem[rd_ptr];
      o_level   = count;
   end

   // Storage array, no reset needed: validity is tracked by count.
   always_ff @(posedge i_clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/median_axis_tx_buffer.sv
// Output stage of the median 5x5 pipeline: buffers the valid-only pixel
// stream and drives an AXI4-Stream video master with tuser/tlast rebuilt
// from runtime WIDTH/HEIGHT.
// Optional: define MEDIAN_TX_DROP_COUNT_EN to add the o_drop_count port.
module median_axis_tx_buffer
   import median_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIM_WIDTH  = MEDIAN_DIM_WIDTH
) (
   input  logic                           i_clk,
   input  logic                           i_areset,
   input  logic [DIM_WIDTH-1:0]           WIDTH,
   input  logic [DIM_WIDTH-1:0]           HEIGHT,
   input  logic [DATA_WIDTH-1:0]          i_median_pixel,
   input  logic                           i_image_data_valid,
   input  logic                           i_start_of_frame,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tuser,
   output logic                           m_axis_tlast,
   output logic                           o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level,
`ifdef MEDIAN_TX_DROP_COUNT_EN
   output logic [15:0]                    o_drop_count,
`endif
   output logic                           o_frame_done
);

   localparam int unsigned EW = fifo_entry_width(DATA_WIDTH);

   typedef struct packed {
      logic                  sof;
      logic [DATA_WIDTH-1:0] data;
   } fifo_entry_t;

   tx_state_t            state;
   tx_state_t            state_nxt;
   fifo_entry_t          wr_entry;
   fifo_entry_t          head;
   logic [EW-1:0]        head_bits;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 sof_in;
   logic                 wr_req;
   logic                 rd_fire;
   logic                 drop;
   logic                 head_sof;
   logic                 head_last_col;
   logic                 frame_end;
   logic [DIM_WIDTH-1:0] w_lat;
   logic [DIM_WIDTH-1:0] h_lat;
   logic [DIM_WIDTH-1:0] col;
   logic [DIM_WIDTH-1:0] row;
   logic [DIM_WIDTH-1:0] eff_col;
   logic [DIM_WIDTH-1:0] eff_row;

   // Input side: only sof pixels get through while IDLE.
   always_comb begin
      sof_in        = i_image_data_valid && i_start_of_frame;
      wr_req        = i_image_data_valid && ((state != IDLE) || i_start_of_frame);
      wr_entry.sof  = i_start_of_frame;
      wr_entry.data = i_median_pixel;
      head          = fifo_entry_t'(head_bits);
      rd_fire       = !fifo_empty && m_axis_tready;
      drop          = wr_req && fifo_full && !rd_fire;
   end

   median_tx_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_areset  (i_areset),
      .i_wr_en   (wr_req),
      .i_wr_data (wr_entry),
      .i_rd_en   (rd_fire),
      .o_rd_data (head_bits),
      .o_full    (fifo_full),
      .o_empty   (fifo_empty),
      .o_level   (o_fifo_level)
   );

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) state <= IDLE;
      else          state <= state_nxt;
   end

   // FSM next state: a new sof always (re)enters ACTIVE, even over a frame end.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sof_in) state_nxt = ACTIVE;
         ACTIVE:  if (!sof_in && rd_fire && frame_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM/stream outputs: a sof head forces position (0,0) for its own beat.
   always_comb begin
      m_axis_tvalid = !fifo_empty;
      head_sof      = !fifo_empty && head.sof;
      eff_col       = head_sof ? '0 : col;
      eff_row       = head_sof ? '0 : row;
      head_last_col = (eff_col == w_lat - 1'b1);
      frame_end     = head_last_col && (eff_row == h_lat - 1'b1);
      m_axis_tdata  = m_axis_tvalid ? head.data : '0;
      m_axis_tuser  = head_sof;
      m_axis_tlast  = m_axis_tvalid && head_last_col;
      o_frame_done  = rd_fire && frame_end;
   end

   // Frame geometry, latched on every valid sof (even a dropped one).
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         w_lat <= DIM_WIDTH'(1);
         h_lat <= DIM_WIDTH'(1);
      end else if (sof_in) begin
         w_lat <= (WIDTH  == '0) ? DIM_WIDTH'(1) : WIDTH;
         h_lat <= (HEIGHT == '0) ? DIM_WIDTH'(1) : HEIGHT;
      end
   end

   // Output position counters, advanced only on a read handshake.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         col <= '0;
         row <= '0;
      end else if (rd_fire) begin
         if (frame_end) begin
            col <= '0;
            row <= '0;
         end else if (head_last_col) begin
            col <= '0;
            row <= eff_row + 1'b1;
         end else begin
            col <= eff_col + 1'b1;
            row <= eff_row;
         end
      end
   end

   // Sticky overflow on any dropped pixel.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset)  o_overflow <= 1'b0;
      else if (drop) o_overflow <= 1'b1;
   end

`ifdef MEDIAN_TX_DROP_COUNT_EN
   // Saturating count of dropped pixels.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset)                        o_drop_count <= '0;
      else if (drop && o_drop_count != '1) o_drop_count <= o_drop_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_median_axis_tx_buffer.sv
// Self-checking bench for median_axis_tx_buffer: a queue-based reference
// model checked every cycle, plus literal checks on the logged beats.
// Honours MEDIAN_TX_DROP_COUNT_EN when defined.
module tb_median_axis_tx_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int DIMW  = 13;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic            i_clk = 1'b0;
   logic            i_areset;
   logic [DIMW-1:0] WIDTH;
   logic [DIMW-1:0] HEIGHT;
   logic [DW-1:0]   i_median_pixel;
   logic            i_image_data_valid;
   logic            i_start_of_frame;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            m_axis_tuser;
   logic            m_axis_tlast;
   logic            o_overflow;
   logic [LW-1:0]   o_fifo_level;
   logic            o_frame_done;
`ifdef MEDIAN_TX_DROP_COUNT_EN
   logic [15:0]     o_drop_count;
`endif

   always #5 i_clk = ~i_clk;

   median_axis_tx_buffer #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .DIM_WIDTH  (DIMW)
   ) dut (
      .i_clk              (i_clk),
      .i_areset           (i_areset),
      .WIDTH              (WIDTH),
      .HEIGHT             (HEIGHT),
      .i_median_pixel     (i_median_pixel),
      .i_image_data_valid (i_image_data_valid),
      .i_start_of_frame   (i_start_of_frame),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tuser       (m_axis_tuser),
      .m_axis_tlast       (m_axis_tlast),
      .o_overflow         (o_overflow),
      .o_fifo_level       (o_fifo_level),
`ifdef MEDIAN_TX_DROP_COUNT_EN
      .o_drop_count       (o_drop_count),
`endif
      .o_frame_done       (o_frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic          sof;
      logic [DW-1:0] d;
   } ent_t;

   ent_t mq[$];
   bit   m_active;
   int   m_w, m_h, m_col, m_row, m_drops;
   bit   m_ovf;

   always @(posedge i_clk or posedge i_areset) begin : model
      bit   hs, last, wr;
      int   ec, er;
      ent_t e;
      if (i_areset) begin
         mq.delete();
         m_active = 0; m_col = 0; m_row = 0;
         m_ovf = 0; m_drops = 0; m_w = 1; m_h = 1;
      end else begin
         hs   = (mq.size() > 0) && (m_axis_tready === 1'b1);
         ec   = (mq.size() > 0 && mq[0].sof) ? 0 : m_col;
         er   = (mq.size() > 0 && mq[0].sof) ? 0 : m_row;
         last = hs && (ec == m_w - 1) && (er == m_h - 1);
         wr   = i_image_data_valid && (m_active || i_start_of_frame);
         if (hs) begin
            if (last)               begin m_col = 0; m_row = 0; end
            else if (ec == m_w - 1) begin m_col = 0; m_row = er + 1; end
            else                    begin m_col = ec + 1; m_row = er; end
            void'(mq.pop_front());
         end
         if (wr) begin
            // pop already applied, so a full+read write finds room here
            if (mq.size() < DEPTH) begin
               e.sof = i_start_of_frame;
               e.d   = i_median_pixel;
               mq.push_back(e);
            end else begin
               m_ovf = 1;
               if (m_drops < 65535) m_drops++;
            end
         end
         if (i_image_data_valid && i_start_of_frame) begin
            m_active = 1;
            m_w = (WIDTH  == 0) ? 1 : int'(WIDTH);
            m_h = (HEIGHT == 0) ? 1 : int'(HEIGHT);
         end else if (last) begin
            m_active = 0;
         end
      end
   end

   // ---------------- per-cycle compare + beat log ----------------
   typedef struct {
      logic [DW-1:0] d;
      logic          u;
      logic          l;
   } beat_t;

   beat_t blog[$];
   int    done_cnt = 0;

   always @(negedge i_clk) begin : compare
      bit ev;
      int ec, er;
      beat_t b;
      ev = mq.size() > 0;
      chk("tvalid", {31'd0, m_axis_tvalid}, {31'd0, ev});
      chk("level", 32'(o_fifo_level), 32'(mq.size()));
      chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
`ifdef MEDIAN_TX_DROP_COUNT_EN
      chk("drop_count", 32'(o_drop_count), 32'(m_drops));
`endif
      if (ev) begin
         ec = mq[0].sof ? 0 : m_col;
         er = mq[0].sof ? 0 : m_row;
         chk("tdata", 32'(m_axis_tdata), 32'(mq[0].d));
         chk("tuser", {31'd0, m_axis_tuser}, {31'd0, mq[0].sof});
         chk("tlast", {31'd0, m_axis_tlast}, {31'd0, ec == m_w - 1});
         chk("frame_done", {31'd0, o_frame_done},
             {31'd0, (m_axis_tready === 1'b1) && ec == m_w - 1 && er == m_h - 1});
      end else begin
         chk("frame_done_idle", {31'd0, o_frame_done}, 32'd0);
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         b.d = m_axis_tdata; b.u = m_axis_tuser; b.l = m_axis_tlast;
         blog.push_back(b);
      end
      if (o_frame_done === 1'b1) done_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic px(input logic [DW-1:0] d, input logic s);
      i_image_data_valid = 1'b1;
      i_start_of_frame   = s;
      i_median_pixel     = d;
      step();
      i_image_data_valid = 1'b0;
      i_start_of_frame   = 1'b0;
   endtask

   task automatic idle(input int n);
      i_image_data_valid = 1'b0;
      i_start_of_frame   = 1'b0;
      repeat (n) step();
   endtask

   task automatic do_reset();
      i_areset = 1'b1;
      idle(2);
      i_areset = 1'b0;
      step();
      blog.delete();
      done_cnt = 0;
   endtask

   function automatic logic [31:0] bd(input int i);
      return (i < blog.size()) ? 32'(blog[i].d) : 32'hDEAD;
   endfunction
   function automatic logic [31:0] bu(input int i);
      return (i < blog.size()) ? {31'd0, blog[i].u} : 32'hDEAD;
   endfunction
   function automatic logic [31:0] bl(input int i);
      return (i < blog.size()) ? {31'd0, blog[i].l} : 32'hDEAD;
   endfunction

   initial begin
      i_areset           = 1'b1;
      WIDTH              = '0;
      HEIGHT             = '0;
      i_median_pixel     = '0;
      i_image_data_valid = 1'b0;
      i_start_of_frame   = 1'b0;
      m_axis_tready      = 1'b1;
      #1;
      chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("rst_level", 32'(o_fifo_level), 32'd0);
      chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
      do_reset();

      // 1: basic 4x3 frame
      WIDTH = 13'd4; HEIGHT = 13'd3; m_axis_tready = 1'b1;
      for (int i = 1; i <= 12; i++) px(DW'(i), i == 1);
      idle(4);
      chk("t1_beats", 32'(blog.size()), 32'd12);
      for (int i = 0; i < 12; i++) begin
         chk("t1_data", bd(i), 32'(i + 1));
         chk("t1_user", bu(i), (i == 0) ? 32'd1 : 32'd0);
         chk("t1_last", bl(i), (i == 3 || i == 7 || i == 11) ? 32'd1 : 32'd0);
      end
      chk("t1_done", 32'(done_cnt), 32'd1);
      chk("t1_ovf", {31'd0, o_overflow}, 32'd0);

      // 2: stalled sink, 20 pixels into a 16-deep FIFO
      do_reset();
      WIDTH = 13'd8; HEIGHT = 13'd4; m_axis_tready = 1'b0;
      for (int i = 1; i <= 20; i++) px(DW'(i), i == 1);
      chk("t2_level", 32'(o_fifo_level), 32'd16);
      chk("t2_ovf", {31'd0, o_overflow}, 32'd1);
      chk("t2_head", 32'(m_axis_tdata), 32'd1);
`ifdef MEDIAN_TX_DROP_COUNT_EN
      chk("t2_drops", 32'(o_drop_count), 32'd4);
`endif
      idle(3);
      chk("t2_head_stable", 32'(m_axis_tdata), 32'd1);

      // 3: full FIFO with simultaneous read and write
      m_axis_tready = 1'b1;
      px(DW'(21), 1'b0);
      chk("t3_level", 32'(o_fifo_level), 32'd16);
`ifdef MEDIAN_TX_DROP_COUNT_EN
      chk("t3_drops", 32'(o_drop_count), 32'd4);
`endif
      for (int i = 22; i <= 32; i++) px(DW'(i), 1'b0);
      chk("t3_level_hold", 32'(o_fifo_level), 32'd16);
      idle(20);
      chk("t3_beats", 32'(blog.size()), 32'd28);
      chk("t3_b0", bd(0), 32'd1);
      chk("t3_b15", bd(15), 32'd16);
      chk("t3_b16", bd(16), 32'd21);
      chk("t3_b27", bd(27), 32'd32);
      chk("t3_last7", bl(7), 32'd1);
      chk("t3_last23", bl(23), 32'd1);
      chk("t3_user16", bu(16), 32'd0);
      chk("t3_done", 32'(done_cnt), 32'd0);

      // 4: garbage before the first sof
      do_reset();
      WIDTH = 13'd2; HEIGHT = 13'd2;
      for (int i = 0; i < 5; i++) px(DW'(8'hA0 + i), 1'b0);
      idle(2);
      chk("t4_no_beats", 32'(blog.size()), 32'd0);
      chk("t4_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("t4_ovf", {31'd0, o_overflow}, 32'd0);
      for (int i = 1; i <= 4; i++) px(DW'(i), i == 1);
      idle(3);
      chk("t4_beats", 32'(blog.size()), 32'd4);
      chk("t4_first", bd(0), 32'd1);
      chk("t4_user0", bu(0), 32'd1);
      chk("t4_last1", bl(1), 32'd1);
      chk("t4_last3", bl(3), 32'd1);
      chk("t4_done", 32'(done_cnt), 32'd1);

      // 5: sof again on the 6th pixel
      do_reset();
      WIDTH = 13'd4; HEIGHT = 13'd2;
      for (int i = 1; i <= 9; i++) px(DW'(i), i == 1 || i == 6);
      idle(3);
      chk("t5_beats", 32'(blog.size()), 32'd9);
      chk("t5_user5", bu(5), 32'd1);
      chk("t5_user4", bu(4), 32'd0);
      chk("t5_last3", bl(3), 32'd1);
      chk("t5_last4", bl(4), 32'd0);
      chk("t5_last5", bl(5), 32'd0);
      chk("t5_last8", bl(8), 32'd1);
      chk("t5_done", 32'(done_cnt), 32'd0);

      // 6: reset with 5 entries buffered
      do_reset();
      WIDTH = 13'd4; HEIGHT = 13'd3; m_axis_tready = 1'b0;
      for (int i = 1; i <= 5; i++) px(DW'(i), i == 1);
      chk("t6_level_pre", 32'(o_fifo_level), 32'd5);
      i_areset = 1'b1;
      #1;
      chk("t6_tvalid_rst", {31'd0, m_axis_tvalid}, 32'd0);
      chk("t6_level_rst", 32'(o_fifo_level), 32'd0);
      step();
      i_areset = 1'b0;
      step();
      blog.delete();
      done_cnt = 0;
      WIDTH = 13'd4; HEIGHT = 13'd1; m_axis_tready = 1'b1;
      for (int i = 1; i <= 4; i++) px(DW'(8'h40 + i), i == 1);
      idle(3);
      chk("t6_beats", 32'(blog.size()), 32'd4);
      chk("t6_first", bd(0), 32'h41);
      chk("t6_user0", bu(0), 32'd1);
      chk("t6_last0", bl(0), 32'd0);
      chk("t6_last3", bl(3), 32'd1);
      chk("t6_done", 32'(done_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
